// File: rtl/irq_pkg.sv
// Shared types and code/source helpers for the interrupt requester.
package irq_pkg;

  localparam int unsigned NSRC = 3;
  localparam int unsigned CW   = 2;
  localparam int unsigned SW   = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [CW-1:0] CODE_NONE = '0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Source index i carries cause code i+1; code 0 means no interrupt.
  function automatic logic [CW-1:0] src2code(input logic [SW-1:0] src);
    return CW'(src) + CW'(1);
  endfunction

  function automatic logic [SW-1:0] code2src(input logic [CW-1:0] code);
    return SW'(code - CW'(1));
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Priority encoder: highest set bit index + 1, or 0 when the vector is empty.
module irq_prio_enc #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] code
);

  always_comb begin
    code = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) code = W'(i + 1);
    end
  end

endmodule

// File: rtl/irq_requester.sv
// Interrupt initiator: edge-detects sources, holds them pending, masks, priority-encodes
// and raises a cause-coded request; tracks in-service levels for nesting and ERET.
module irq_requester
  import irq_pkg::*;
(
  input  logic            in_clk,
  input  logic            in_RST,
  input  logic [NSRC-1:0] in_irq,
  input  logic            in_IE,
  input  logic [NSRC:0]   in_INM,
  input  logic            in_ack,
  input  logic            in_eret,
  output logic            out_req,
  output logic [CW-1:0]   out_code,
  output logic [NSRC-1:0] out_pending,
  output logic [NSRC-1:0] out_inservice,
  output logic [CW-1:0]   out_level
);

  state_t          state_q, state_d;
  logic            req_q;
  logic            holdoff_q;
  logic            ack_take;
  logic [CW-1:0]   code_q, code_d;
  logic [CW-1:0]   cand;
  logic [CW-1:0]   level_q, level_d;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] inservice_q, inservice_d;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] ack_vec;
  logic [NSRC-1:0] eret_vec;

  assign rise = in_irq & ~irq_q;

  // A source may request only when unmasked and strictly above the current in-service level.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      eligible[i] = pending_q[i] & ~in_INM[i+1] & (src2code(SW'(i)) > level_q);
    end
  end

  irq_prio_enc #(.N(NSRC), .W(CW)) u_cand_enc (
    .vec  (eligible),
    .code (cand)
  );

  // Level is registered from the next in-service vector so it tracks inservice_q exactly.
  irq_prio_enc #(.N(NSRC), .W(CW)) u_level_enc (
    .vec  (inservice_d),
    .code (level_d)
  );

  // Request FSM; holdoff_q enforces one idle cycle after an ack before the next request.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    ack_take = 1'b0;
    case (state_q)
      IDLE: begin
        code_d = CODE_NONE;
        if (in_IE && (cand != CODE_NONE) && !holdoff_q) begin
          state_d = REQ;
          code_d  = cand;
        end
      end
      REQ: begin
        if (in_ack) begin
          ack_take = 1'b1;
          state_d  = IDLE;
          code_d   = CODE_NONE;
        end else if (!in_IE || in_INM[code_q] || (code_q <= level_q)) begin
          state_d = IDLE;
          code_d  = CODE_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = CODE_NONE;
      end
    endcase
  end

  // ERET retires the highest in-service level before the ack adds the new one.
  always_comb begin
    ack_vec  = '0;
    eret_vec = '0;
    if (ack_take) ack_vec[code2src(code_q)] = 1'b1;
    if (in_eret && (level_q != CODE_NONE)) eret_vec[code2src(level_q)] = 1'b1;
    pending_d   = (pending_q & ~ack_vec) | rise;
    inservice_d = (inservice_q & ~eret_vec) | ack_vec;
  end

  always_ff @(posedge in_clk) begin
    if (in_RST) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      code_q      <= CODE_NONE;
      holdoff_q   <= 1'b0;
      irq_q       <= '0;
      pending_q   <= '0;
      inservice_q <= '0;
      level_q     <= CODE_NONE;
    end else begin
      state_q     <= state_d;
      req_q       <= (state_d == REQ);
      code_q      <= code_d;
      holdoff_q   <= ack_take;
      irq_q       <= in_irq;
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      level_q     <= level_d;
    end
  end

  assign out_req       = req_q;
  assign out_code      = code_q;
  assign out_pending   = pending_q;
  assign out_inservice = inservice_q;
  assign out_level     = level_q;

endmodule

// File: tb/tb_irq_requester.sv
// Directed and random bench for irq_requester against a cycle-level behavioural model.
module tb_irq_requester;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] irq = 3'b000;
  logic       ie = 1'b0;
  logic [3:0] inm = 4'b0000;
  logic       ack = 1'b0;
  logic       eret = 1'b0;
  logic       out_req;
  logic [1:0] out_code;
  logic [2:0] out_pending;
  logic [2:0] out_inservice;
  logic [1:0] out_level;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       m_req;
  int       m_code;
  bit       m_hold;
  bit [2:0] m_pend;
  bit [2:0] m_ins;
  bit [2:0] m_prev;

  always #5 clk = ~clk;

  irq_requester dut (
    .in_clk        (clk),
    .in_RST        (rst),
    .in_irq        (irq),
    .in_IE         (ie),
    .in_INM        (inm),
    .in_ack        (ack),
    .in_eret       (eret),
    .out_req       (out_req),
    .out_code      (out_code),
    .out_pending   (out_pending),
    .out_inservice (out_inservice),
    .out_level     (out_level)
  );

  function automatic int top_code(input bit [2:0] v);
    for (int i = 2; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees at that edge.
  task automatic model_edge();
    int  lvl;
    int  cand;
    int  old_code;
    bit  take;
    if (rst) begin
      m_req = 0; m_code = 0; m_hold = 0; m_pend = 0; m_ins = 0; m_prev = 0;
      return;
    end
    lvl  = top_code(m_ins);
    cand = 0;
    for (int c = 1; c <= 3; c++) if (m_pend[c-1] && !inm[c] && c > lvl) cand = c;
    old_code = m_code;
    take     = 0;
    if (m_req) begin
      if (ack) begin
        take  = 1;
        m_req = 0;
      end else if (!ie || inm[m_code] || m_code <= lvl) begin
        m_req = 0;
      end
    end else if (ie && cand != 0 && !m_hold) begin
      m_req  = 1;
      m_code = cand;
    end
    if (eret && lvl != 0) m_ins[lvl-1] = 0;
    if (take) begin
      m_pend[old_code-1] = 0;
      m_ins[old_code-1]  = 1;
    end
    m_pend = m_pend | (irq & ~m_prev);
    m_prev = irq;
    m_hold = take;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_req",       32'(out_req),       32'(m_req));
    chk("model_code",      32'(out_code),      32'(m_req ? m_code : 0));
    chk("model_pending",   32'(out_pending),   32'(m_pend));
    chk("model_inservice", 32'(out_inservice), 32'(m_ins));
    chk("model_level",     32'(out_level),     32'(top_code(m_ins)));
  endtask

  task automatic expect_out(input string tag, input logic r, input logic [1:0] c,
                            input logic [2:0] p, input logic [2:0] s, input logic [1:0] l);
    chk({tag, ".req"},   32'(out_req),       32'(r));
    chk({tag, ".code"},  32'(out_code),      32'(c));
    chk({tag, ".pend"},  32'(out_pending),   32'(p));
    chk({tag, ".ins"},   32'(out_inservice), 32'(s));
    chk({tag, ".level"}, 32'(out_level),     32'(l));
  endtask

  initial begin
    // Reset then idle
    rst = 1; tick(); tick();
    expect_out("reset", 0, 0, 3'b000, 3'b000, 0);
    rst = 0;
    for (int n = 0; n < 10; n++) tick();
    expect_out("idle", 0, 0, 3'b000, 3'b000, 0);

    // Single source, one-cycle request latency, ack
    ie = 1; inm = 4'b0000;
    irq = 3'b001; tick(); expect_out("s2_pend", 0, 0, 3'b001, 3'b000, 0);
    tick();                expect_out("s2_req",  1, 1, 3'b001, 3'b000, 0);
    tick();                expect_out("s2_hold", 1, 1, 3'b001, 3'b000, 0);
    ack = 1; tick();       expect_out("s2_ack",  0, 0, 3'b000, 3'b001, 1);
    ack = 0; irq = 3'b000; tick();
    eret = 1; tick();      expect_out("s2_eret", 0, 0, 3'b000, 3'b000, 0);
    eret = 0;

    // Priority and nesting
    irq = 3'b101; tick();  expect_out("s3_pend", 0, 0, 3'b101, 3'b000, 0);
    tick();                expect_out("s3_req3", 1, 3, 3'b101, 3'b000, 0);
    ack = 1; tick();       expect_out("s3_ack3", 0, 0, 3'b001, 3'b100, 3);
    ack = 0; irq = 3'b000; tick();
    irq = 3'b010; tick();  expect_out("s3_low",  0, 0, 3'b011, 3'b100, 3);
    tick();                expect_out("s3_wait", 0, 0, 3'b011, 3'b100, 3);
    eret = 1; tick();      expect_out("s3_eret", 0, 0, 3'b011, 3'b000, 0);
    eret = 0; tick();      expect_out("s3_req2", 1, 2, 3'b011, 3'b000, 0);

    // Mask withdraw and re-request
    inm = 4'b0100; tick(); expect_out("s4_wdraw", 0, 0, 3'b011, 3'b000, 0);
    inm = 4'b0000; tick(); expect_out("s4_rereq", 1, 2, 3'b011, 3'b000, 0);
    ack = 1; tick();       expect_out("s4_ack",   0, 0, 3'b001, 3'b010, 2);
    ack = 0; irq = 3'b000; tick();
    expect_out("s4_nested", 0, 0, 3'b001, 3'b010, 2);

    // Ack and new rise on the same source: set wins
    eret = 1; tick();      expect_out("s5_eret", 0, 0, 3'b001, 3'b000, 0);
    eret = 0; tick();      expect_out("s5_req1", 1, 1, 3'b001, 3'b000, 0);
    ack = 1; irq = 3'b001; tick();
    expect_out("s5_ackrise", 0, 0, 3'b001, 3'b001, 1);
    ack = 0; tick();

    // ERET and ack in the same cycle
    irq = 3'b011; tick();  expect_out("s5_pend2", 0, 0, 3'b011, 3'b001, 1);
    tick();                expect_out("s5_req2",  1, 2, 3'b011, 3'b001, 1);
    ack = 1; eret = 1; tick();
    expect_out("s5_eretack", 0, 0, 3'b001, 3'b010, 2);
    ack = 0; eret = 0; irq = 3'b000; tick();

    // ERET with nothing in service
    ie = 0;
    eret = 1; tick();      expect_out("s5_eret_a", 0, 0, 3'b001, 3'b000, 0);
    tick();                expect_out("s5_eret_0", 0, 0, 3'b001, 3'b000, 0);
    eret = 0;

    // Reset mid-request, then IE=0 blocks everything
    ie = 1; tick();        expect_out("s6_req",  1, 1, 3'b001, 3'b000, 0);
    rst = 1; tick();       expect_out("s6_rst",  0, 0, 3'b000, 3'b000, 0);
    rst = 0; ie = 0; irq = 3'b111; tick();
    expect_out("s6_pend", 0, 0, 3'b111, 3'b000, 0);
    for (int n = 0; n < 6; n++) tick();
    expect_out("s6_noie", 0, 0, 3'b111, 3'b000, 0);
    irq = 3'b000; tick();

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(2) == 0) irq = 3'($urandom);
      ie   = ($urandom_range(7) != 0);
      inm  = ($urandom_range(3) == 0) ? (4'($urandom) & 4'b1110) : 4'b0000;
      ack  = ($urandom_range(2) == 0);
      eret = ($urandom_range(5) == 0);
      rst  = ($urandom_range(199) == 0);
      tick();
    end
    rst = 0; ack = 0; eret = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
